// File: rtl/flag_event_queue_pkg.sv
// Shared definitions for the flag event queue: FSM state encoding.
`timescale 1ns/1ps
package flag_event_queue_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Encoding 2'd3 is unused; the FSM default branch recovers it to idle.
  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StHold = ST_HOLD,
    StWait = ST_WAIT
  } state_e;

endpackage

// File: rtl/flag_event_queue_if.sv
// Event/status bundle between a source-domain producer and the flag event queue.
`timescale 1ns/1ps
interface flag_event_queue_if #(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TOTAL_WIDTH = 32
);
  logic                   event_in;
  logic                   clear;
  logic                   busy_in;
  logic                   flag_out;
  logic [COUNT_WIDTH-1:0] pending;
  logic                   overflow;
  logic [TOTAL_WIDTH-1:0] issued_total;

  modport master (
    output event_in, clear, busy_in,
    input  flag_out, pending, overflow, issued_total
  );

  modport slave (
    input  event_in, clear, busy_in,
    output flag_out, pending, overflow, issued_total
  );
endinterface

// File: rtl/flag_event_queue_sat_updown_counter.sv
// Saturating up/down counter holding the pending-event count and detecting dropped events.
`timescale 1ns/1ps
module flag_event_queue_sat_updown_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] clr_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             sat_drop
);

  logic [WIDTH-1:0] r_count;
  logic             w_sat;
  logic             w_inc;

  // A simultaneous decrement frees a slot, so the counter is not saturated that cycle.
  assign w_sat    = (&r_count) && !dec;
  assign w_inc    = inc && !w_sat;
  assign sat_drop = inc && w_sat;
  assign count    = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= clr_val;
    end else if (w_inc && !dec) begin
      r_count <= r_count + WIDTH'(1);
    end else if (!w_inc && dec) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/flag_event_queue.sv
// Queues source-domain event pulses and reissues them one at a time to a busy-handshaked
// flag crossing stage.
`timescale 1ns/1ps
module flag_event_queue
  import flag_event_queue_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TOTAL_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  flag_event_queue_if.slave bus
);

  state_e                 r_state;
  logic                   r_flag;
  logic                   r_overflow;
  logic [TOTAL_WIDTH-1:0] r_total;
  logic [COUNT_WIDTH-1:0] w_count;
  logic [COUNT_WIDTH-1:0] w_clr_val;
  logic                   w_issue;
  logic                   w_sat_drop;

  assign w_issue   = (r_state == StIdle) && (w_count != '0) && !bus.busy_in;
  assign w_clr_val = COUNT_WIDTH'(bus.event_in);

  flag_event_queue_sat_updown_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_pending (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.clear),
    .clr_val  (w_clr_val),
    .inc      (bus.event_in),
    .dec      (w_issue),
    .count    (w_count),
    .sat_drop (w_sat_drop)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_flag  <= 1'b0;
      r_total <= '0;
    end else begin
      r_flag <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_flag  <= 1'b1;
            r_total <= r_total + TOTAL_WIDTH'(1);
            r_state <= StHold;
          end
        end
        // Guard cycle: downstream busy only rises one cycle after it samples the flag.
        StHold: r_state <= StWait;
        StWait: if (!bus.busy_in) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_overflow <= 1'b0;
    end else if (w_sat_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.flag_out     = r_flag;
  assign bus.pending      = w_count;
  assign bus.overflow     = r_overflow;
  assign bus.issued_total = r_total;

endmodule

// File: tb/tb_flag_event_queue.sv
// Directed self-checking bench for flag_event_queue, including a toggle-handshake crossing model.
`timescale 1ns/1ps
module tb_flag_event_queue;
  import flag_event_queue_pkg::*;

  logic clk = 1'b0;
  logic clk_out = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always #15 clk_out = ~clk_out;

  flag_event_queue_if #(.COUNT_WIDTH(8), .TOTAL_WIDTH(32)) bus1 ();
  flag_event_queue_if #(.COUNT_WIDTH(2), .TOTAL_WIDTH(2))  bus2 ();

  flag_event_queue #(.COUNT_WIDTH(8), .TOTAL_WIDTH(32)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  flag_event_queue #(.COUNT_WIDTH(2), .TOTAL_WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // Toggle-based flag crossing model into the slower clk_out domain.
  logic use_cdc, busy1_drv;
  logic cdc_req, dst_s1, dst_s2, dst_s3, ack_s1, ack_s2;
  int   dst_pulses;

  assign bus1.busy_in = use_cdc ? (cdc_req ^ ack_s2) : busy1_drv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdc_req <= 1'b0;
      ack_s1  <= 1'b0;
      ack_s2  <= 1'b0;
    end else begin
      if (bus1.flag_out) cdc_req <= ~cdc_req;
      ack_s1 <= dst_s3;
      ack_s2 <= ack_s1;
    end
  end

  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      dst_s1     <= 1'b0;
      dst_s2     <= 1'b0;
      dst_s3     <= 1'b0;
      dst_pulses <= 0;
    end else begin
      dst_s1 <= cdc_req;
      dst_s2 <= dst_s1;
      dst_s3 <= dst_s2;
      if (dst_s2 != dst_s3) dst_pulses <= dst_pulses + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus1.flag_out !== 1'b0) begin errors++; $display("FAIL reset_flag got %0b want 0", bus1.flag_out); end
    checks++; if (bus1.pending !== 8'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", bus1.pending); end
    checks++; if (bus1.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", bus1.overflow); end
    checks++; if (bus1.issued_total !== 32'd0) begin errors++; $display("FAIL reset_total got %0d want 0", bus1.issued_total); end
    checks++; if (bus2.pending !== 2'd0) begin errors++; $display("FAIL reset_pending2 got %0d want 0", bus2.pending); end
    do_reset();
  endtask

  task automatic test_reset_mid_wait();
    int flags;
    bus1.event_in = 1'b1; step();
    bus1.event_in = 1'b0; step();
    checks++; if (bus1.flag_out !== 1'b1) begin errors++; $display("FAIL midwait_first_flag got %0b want 1", bus1.flag_out); end
    busy1_drv = 1'b1; bus1.event_in = 1'b1; step();
    bus1.event_in = 1'b0; repeat (2) step();
    checks++; if (dut1.r_state !== StWait) begin errors++; $display("FAIL midwait_state got %0d want %0d", dut1.r_state, StWait); end
    checks++; if (bus1.pending !== 8'd1) begin errors++; $display("FAIL midwait_pending got %0d want 1", bus1.pending); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus1.flag_out !== 1'b0) begin errors++; $display("FAIL async_rst_flag got %0b want 0", bus1.flag_out); end
    checks++; if (bus1.pending !== 8'd0) begin errors++; $display("FAIL async_rst_pending got %0d want 0", bus1.pending); end
    checks++; if (dut1.r_state !== StIdle) begin errors++; $display("FAIL async_rst_state got %0d want %0d", dut1.r_state, StIdle); end
    checks++; if (bus1.issued_total !== 32'd0) begin errors++; $display("FAIL async_rst_total got %0d want 0", bus1.issued_total); end
    #1 reset = 1'b0;
    busy1_drv = 1'b0;
    flags = 0;
    repeat (6) begin step(); if (bus1.flag_out) flags++; end
    checks++; if (flags !== 0) begin errors++; $display("FAIL post_rst_flags got %0d want 0", flags); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_pend [8] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
    logic       exp_flag [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      bus1.event_in = (i < 3);
      step();
      checks++; if (bus1.pending !== exp_pend[i]) begin errors++; $display("FAIL b2b_pending[%0d] got %0d want %0d", i, bus1.pending, exp_pend[i]); end
      checks++; if (bus1.flag_out !== exp_flag[i]) begin errors++; $display("FAIL b2b_flag[%0d] got %0b want %0b", i, bus1.flag_out, exp_flag[i]); end
    end
    bus1.event_in = 1'b0;
    checks++; if (bus1.issued_total !== 32'd3) begin errors++; $display("FAIL b2b_total got %0d want 3", bus1.issued_total); end
    repeat (3) step();
  endtask

  task automatic test_busy_hold();
    int flags;
    do_reset();
    bus1.event_in = 1'b1; step();
    bus1.event_in = 1'b0; step();
    checks++; if (bus1.flag_out !== 1'b1) begin errors++; $display("FAIL busy_first_flag got %0b want 1", bus1.flag_out); end
    busy1_drv = 1'b1;
    flags = 0;
    for (int i = 0; i < 20; i++) begin
      bus1.event_in = (i == 2 || i == 5 || i == 8 || i == 11 || i == 14);
      step();
      if (bus1.flag_out) flags++;
    end
    bus1.event_in = 1'b0;
    checks++; if (flags !== 0) begin errors++; $display("FAIL busy_flags_while_busy got %0d want 0", flags); end
    checks++; if (bus1.pending !== 8'd5) begin errors++; $display("FAIL busy_pending got %0d want 5", bus1.pending); end
    busy1_drv = 1'b0;
    flags = 0;
    repeat (30) begin step(); if (bus1.flag_out) flags++; end
    checks++; if (flags !== 5) begin errors++; $display("FAIL busy_drain_flags got %0d want 5", flags); end
    checks++; if (bus1.issued_total !== 32'd6) begin errors++; $display("FAIL busy_total got %0d want 6", bus1.issued_total); end
    checks++; if (bus1.pending !== 8'd0) begin errors++; $display("FAIL busy_drain_pending got %0d want 0", bus1.pending); end
  endtask

  task automatic test_saturate();
    bus2.event_in = 1'b1; repeat (5) step();
    bus2.event_in = 1'b0;
    checks++; if (bus2.pending !== 2'd3) begin errors++; $display("FAIL sat_pending got %0d want 3", bus2.pending); end
    checks++; if (bus2.overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got %0b want 1", bus2.overflow); end
    bus2.clear = 1'b1; bus2.event_in = 1'b1; step();
    bus2.clear = 1'b0; bus2.event_in = 1'b0;
    checks++; if (bus2.pending !== 2'd1) begin errors++; $display("FAIL clear_pending got %0d want 1", bus2.pending); end
    checks++; if (bus2.overflow !== 1'b0) begin errors++; $display("FAIL clear_overflow got %0b want 0", bus2.overflow); end
    checks++; if (bus2.issued_total !== 2'd0) begin errors++; $display("FAIL sat_total got %0d want 0", bus2.issued_total); end
  endtask

  task automatic test_sat_issue();
    int flags;
    bus2.event_in = 1'b1; repeat (2) step();
    bus2.event_in = 1'b0;
    checks++; if (bus2.pending !== 2'd3) begin errors++; $display("FAIL satiss_pre_pending got %0d want 3", bus2.pending); end
    bus2.busy_in = 1'b0; bus2.event_in = 1'b1; step();
    bus2.event_in = 1'b0;
    checks++; if (bus2.flag_out !== 1'b1) begin errors++; $display("FAIL satiss_flag got %0b want 1", bus2.flag_out); end
    checks++; if (bus2.pending !== 2'd3) begin errors++; $display("FAIL satiss_pending got %0d want 3", bus2.pending); end
    checks++; if (bus2.overflow !== 1'b0) begin errors++; $display("FAIL satiss_overflow got %0b want 0", bus2.overflow); end
    checks++; if (bus2.issued_total !== 2'd1) begin errors++; $display("FAIL satiss_total got %0d want 1", bus2.issued_total); end
    flags = 0;
    repeat (15) begin step(); if (bus2.flag_out) flags++; end
    checks++; if (flags !== 3) begin errors++; $display("FAIL drain2_flags got %0d want 3", flags); end
    checks++; if (bus2.pending !== 2'd0) begin errors++; $display("FAIL drain2_pending got %0d want 0", bus2.pending); end
    checks++; if (bus2.issued_total !== 2'd0) begin errors++; $display("FAIL total_wrap got %0d want 0", bus2.issued_total); end
    bus2.busy_in = 1'b1;
  endtask

  task automatic test_cdc_chain();
    int sent;
    bit done;
    do_reset();
    use_cdc = 1'b1;
    sent = 0;
    for (int i = 0; i < 2000 && sent < 100; i++) begin
      bus1.event_in = 1'($urandom_range(0, 1));
      if (bus1.event_in) sent++;
      step();
    end
    bus1.event_in = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      step();
      if (dst_pulses == 100 && bus1.pending == 8'd0) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL cdc_timeout got %0d dest pulses want 100", dst_pulses); end
    repeat (40) step();
    checks++; if (dst_pulses !== 100) begin errors++; $display("FAIL cdc_dest_pulses got %0d want 100", dst_pulses); end
    checks++; if (bus1.issued_total !== 32'd100) begin errors++; $display("FAIL cdc_total got %0d want 100", bus1.issued_total); end
    checks++; if (bus1.overflow !== 1'b0) begin errors++; $display("FAIL cdc_overflow got %0b want 0", bus1.overflow); end
    use_cdc = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    use_cdc       = 1'b0;
    busy1_drv     = 1'b0;
    bus1.event_in = 1'b0;
    bus1.clear    = 1'b0;
    bus2.event_in = 1'b0;
    bus2.clear    = 1'b0;
    bus2.busy_in  = 1'b1;
    test_reset();
    test_reset_mid_wait();
    test_back_to_back();
    test_busy_hold();
    test_saturate();
    test_sat_issue();
    test_cdc_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
